digit_serial_adder: RTL and testbench
=====================================

// Module: digit_serial_adder
// PURPOSE
//  - Multi-cycle N-bit adder built from a parametrised chain of full-adder cells.
//  - Processes DIGIT bits per clock, LSB first, and holds the carry between cycles in a register.
//  - Uses a start/busy/done handshake.
//  - Sits on the ALU datapath wherever area matters more than latency. It is the
//    sequential, width-generic successor of the single-bit gate-level full adder.
// PARAMETERS
//  - WIDTH  8  operand/result width in bits; WIDTH >= 2.
//  - DIGIT  1  bits processed per cycle. Must divide WIDTH; otherwise elaboration error.
//  - Derived: NDIG = WIDTH/DIGIT = cycles per operation.
// PORTS
//  - clk       in   1      single clock, rising edge.
//  - rst_n     in   1      asynchronous, active-low reset.
//  - start     in   1      request; accepted only in IDLE or DONE.
//  - a         in   WIDTH  operand A, sampled on the accept edge.
//  - b         in   WIDTH  operand B, sampled on the accept edge.
//  - cin       in   1      carry-in, sampled on the accept edge.
//  - op        in   1      0=add, 1=subtract; present only with ADD_SUB_EN.
//  - sum       out  WIDTH  result; valid from done until the next accept.
//  - cout      out  1      final carry-out (add) / no-borrow flag (sub).
//  - overflow  out  1      two's-complement overflow of the result.
//  - busy      out  1      high while in RUN.
//  - done      out  1      one-cycle pulse when the result becomes valid.
// BEHAVIOUR
//  - Reset (async, any time, including mid-operation):
//    - state=IDLE; sum=0, cout=0, overflow=0, busy=0, done=0.
//    - Digit counter and carry register cleared.
//    - An in-flight operation is abandoned with no done pulse.
//  - FSM: IDLE -start-> RUN; RUN -(cnt==NDIG-1)-> DONE; DONE -start-> RUN; DONE -!start-> IDLE.
//  - Accept edge:
//    - Latch a/b into shift registers and load the carry register from cin.
//    - Clear cnt; sum, cout and overflow keep their old values until the new done.
//  - RUN cycle k (k = 0..NDIG-1):
//    - Ripple DIGIT cells over bits [k*DIGIT +: DIGIT] using the registered carry.
//    - Shift the digit result into sum from the MSB end; register the digit carry-out.
//  - Final cycle:
//    - cout = carry out of bit WIDTH-1.
//    - overflow = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1.
//  - Latency: done asserts exactly NDIG+1 edges after the accept edge.
//    - Example: WIDTH=8, DIGIT=1 gives 9 cycles.
//  - busy=1 for exactly NDIG cycles; done and busy are never high together.
//  - start while busy is ignored; operands are not resampled.
//  - start held high through DONE: back-to-back operation.
//    - The done pulse is still emitted, and RUN starts the following cycle.
//  - Arithmetic is modulo 2^WIDTH; no saturation.
// CONFIGURATION
//  - Macro ADD_SUB_EN defined:
//    - Port op exists, sampled on accept.
//    - op=1 computes a - b as a + ~b + 1; cin is ignored and the carry register is forced to 1.
//    - cout=1 means no borrow.
//  - Macro ADD_SUB_EN undefined:
//    - No op port; add only.
// STRUCTURE
//  - Package adder_pkg holds:
//    - the state_t typedef {IDLE, RUN, DONE}, 2 bits;
//    - the function clog2 used to size cnt.
//  - Sub-module fa_cell (a, b, ci -> s, co):
//    - gate-level xor/and/or full adder;
//    - DIGIT instances are generated in a ripple chain.
//  - The top holds the FSM, counter, shift registers and carry/overflow registers.
// TESTING
//  - Reset defaults: W=8, D=1, rst_n low -> all outputs 0, busy=0.
//  - Add with carry-out: 0xFF + 0x01, cin=0 -> busy 8 cycles, done at edge 9,
//    sum=0x00, cout=1, overflow=0.
//  - Signed overflow: 0x7F + 0x01, cin=0 -> sum=0x80, cout=0, overflow=1.
//    Then 0x80 + 0x80 -> sum=0x00, cout=1, overflow=1.
//  - start during busy: 0x03+0x04 accepted, 0xAA+0x55 pulsed at RUN cycle 3
//    -> sum=0x07, single done pulse.
//  - Async reset mid-run: rst_n low at RUN cycle 4 -> outputs 0 immediately, no done.
//    A new 0x10+0x20 afterwards -> sum=0x30.
//  - W=8, D=4, back-to-back: start held; 0x0F+0x01 then 0x01+0x01 -> done every 3 cycles,
//    sums 0x10, 0x02. With ADD_SUB_EN: 0x05-0x07 -> sum=0xFE, cout=0.

Source files
------------

// File: rtl/adder_pkg.sv
// rtl/adder_pkg.sv - shared types and helpers for the digit-serial adder
package adder_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   function automatic int clog2(input int value);
      int result;
      result = 0;
      for (int v = value - 1; v > 0; v = v >> 1) begin
         result = result + 1;
      end
      return result;
   endfunction

endpackage

// File: rtl/digit_serial_adder_if.sv
// rtl/digit_serial_adder_if.sv - start/busy/done operand and result bundle
// The op signal exists only when ADD_SUB_EN is defined.
interface digit_serial_adder_if #(
   parameter int WIDTH = 8
);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
`ifdef ADD_SUB_EN
   logic             op;
`endif
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             overflow;
   logic             busy;
   logic             done;

   modport master (
      output start, a, b, cin,
`ifdef ADD_SUB_EN
      output op,
`endif
      input  sum, cout, overflow, busy, done
   );

   modport slave (
      input  start, a, b, cin,
`ifdef ADD_SUB_EN
      input  op,
`endif
      output sum, cout, overflow, busy, done
   );

endinterface

// File: rtl/fa_cell.sv
// rtl/fa_cell.sv - gate-level full adder cell
module fa_cell (
   input  logic a_i,
   input  logic b_i,
   input  logic ci_i,
   output logic s_o,
   output logic co_o
);

   logic p;
   logic g;
   logic t;

   xor u_x_prop (p, a_i, b_i);
   xor u_x_sum  (s_o, p, ci_i);
   and u_a_gen  (g, a_i, b_i);
   and u_a_prop (t, p, ci_i);
   or  u_o_co   (co_o, g, t);

endmodule

// File: rtl/digit_serial_adder.sv
// rtl/digit_serial_adder.sv - multi-cycle adder, DIGIT bits per clock, LSB first
// Optional subtract mode is enabled by defining ADD_SUB_EN.
module digit_serial_adder
   import adder_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DIGIT = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   digit_serial_adder_if.slave  bus
);

   localparam int NDIG  = WIDTH / DIGIT;
   localparam int CNT_W = (NDIG > 1) ? clog2(NDIG) : 1;

   if (WIDTH < 2 || DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_cfg
      $error("digit_serial_adder: DIGIT must divide WIDTH and WIDTH must be >= 2");
   end

   state_t             state_q;
   logic [CNT_W-1:0]   cnt_q;
   logic [WIDTH-1:0]   a_q;
   logic [WIDTH-1:0]   b_q;
   logic [WIDTH-1:0]   res_q;
   logic [WIDTH-1:0]   sum_q;
   logic               carry_q;
   logic               cout_q;
   logic               ovf_q;
   logic               busy_q;
   logic               done_q;

   logic [WIDTH-1:0]   a_d;
   logic [WIDTH-1:0]   b_d;
   logic [WIDTH-1:0]   res_d;
   logic [DIGIT:0]     c;
   logic [DIGIT-1:0]   s_dig;
   logic               last;
   logic               op_sub;
   logic [WIDTH-1:0]   b_load;
   logic               c_load;

`ifdef ADD_SUB_EN
   assign op_sub = bus.op;
`else
   assign op_sub = 1'b0;
`endif

   // Subtract is a + ~b + 1, so cin is replaced by a forced carry of one.
   assign b_load = op_sub ? ~bus.b : bus.b;
   assign c_load = op_sub ? 1'b1   : bus.cin;

   assign c[0] = carry_q;

   for (genvar i = 0; i < DIGIT; i++) begin : g_cell
      fa_cell u_fa (
         .a_i  (a_q[i]),
         .b_i  (b_q[i]),
         .ci_i (c[i]),
         .s_o  (s_dig[i]),
         .co_o (c[i+1])
      );
   end

   // Each new digit enters at the MSB end so the LSB digit lands at bit 0 after NDIG shifts.
   assign a_d   = a_q >> DIGIT;
   assign b_d   = b_q >> DIGIT;
   assign res_d = (res_q >> DIGIT) | (WIDTH'(s_dig) << (WIDTH - DIGIT));
   assign last  = (cnt_q == CNT_W'(NDIG - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE, DONE: begin
               if (bus.start) begin
                  state_q <= RUN;
                  busy_q  <= 1'b1;
                  cnt_q   <= '0;
                  a_q     <= bus.a;
                  b_q     <= b_load;
                  carry_q <= c_load;
               end else begin
                  state_q <= IDLE;
               end
            end
            RUN: begin
               a_q     <= a_d;
               b_q     <= b_d;
               res_q   <= res_d;
               carry_q <= c[DIGIT];
               cnt_q   <= cnt_q + 1'b1;
               if (last) begin
                  state_q <= DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  sum_q   <= res_d;
                  cout_q  <= c[DIGIT];
                  ovf_q   <= c[DIGIT] ^ c[DIGIT-1];
               end
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.sum      = sum_q;
   assign bus.cout     = cout_q;
   assign bus.overflow = ovf_q;
   assign bus.busy     = busy_q;
   assign bus.done     = done_q;

endmodule

// File: tb/tb_digit_serial_adder.sv
// tb/tb_digit_serial_adder.sv - directed bench for digit_serial_adder (DIGIT=1 and DIGIT=4)
module tb_digit_serial_adder;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   digit_serial_adder_if #(.WIDTH(8)) bus1 ();
   digit_serial_adder_if #(.WIDTH(8)) bus4 ();

   digit_serial_adder #(.WIDTH(8), .DIGIT(1)) u_dut1 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus1.slave)
   );

   digit_serial_adder #(.WIDTH(8), .DIGIT(4)) u_dut4 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus4.slave)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Launch one operation on the DIGIT=1 unit; lat counts edges from accept (edge 1) to done.
   task automatic op1(input logic [7:0] a, input logic [7:0] b, input logic ci,
                      output int lat, output int bcnt);
      int cyc;
      bus1.a     = a;
      bus1.b     = b;
      bus1.cin   = ci;
      bus1.start = 1'b1;
      tick();
      bus1.start = 1'b0;
      cyc  = 1;
      bcnt = 0;
      while (!bus1.done && cyc < 40) begin
         if (bus1.busy) bcnt++;
         tick();
         cyc++;
      end
      lat = cyc;
   endtask

   int         lat;
   int         bn;
   int         dn;
   logic [7:0] cap;

   initial begin
      checks = 0;
      errors = 0;
      rst_n  = 1'b0;
      bus1.start = 1'b0; bus1.a = '0; bus1.b = '0; bus1.cin = 1'b0;
      bus4.start = 1'b0; bus4.a = '0; bus4.b = '0; bus4.cin = 1'b0;
`ifdef ADD_SUB_EN
      bus1.op = 1'b0;
      bus4.op = 1'b0;
`endif
      #12;
      check("rst_sum",      32'(bus1.sum), 32'h0);
      check("rst_cout",     32'(bus1.cout), 32'h0);
      check("rst_overflow", 32'(bus1.overflow), 32'h0);
      check("rst_busy",     32'(bus1.busy), 32'h0);
      check("rst_done",     32'(bus1.done), 32'h0);
      check("rst_busy4",    32'(bus4.busy), 32'h0);
      rst_n = 1'b1;
      tick();

      op1(8'hFF, 8'h01, 1'b0, lat, bn);
      check("ff01_latency", 32'(lat), 32'd9);
      check("ff01_busy_cycles", 32'(bn), 32'd8);
      check("ff01_sum",  32'(bus1.sum), 32'h00);
      check("ff01_cout", 32'(bus1.cout), 32'h1);
      check("ff01_ovf",  32'(bus1.overflow), 32'h0);
      check("ff01_busy_with_done", 32'(bus1.busy), 32'h0);
      tick();
      check("ff01_done_one_cycle", 32'(bus1.done), 32'h0);
      check("ff01_sum_held", 32'(bus1.sum), 32'h00);

      op1(8'h7F, 8'h01, 1'b0, lat, bn);
      check("7f01_sum",  32'(bus1.sum), 32'h80);
      check("7f01_cout", 32'(bus1.cout), 32'h0);
      check("7f01_ovf",  32'(bus1.overflow), 32'h1);
      tick();

      op1(8'h80, 8'h80, 1'b0, lat, bn);
      check("8080_sum",  32'(bus1.sum), 32'h00);
      check("8080_cout", 32'(bus1.cout), 32'h1);
      check("8080_ovf",  32'(bus1.overflow), 32'h1);
      tick();

      // A second start during RUN must be ignored, operands included.
      bus1.a = 8'h03; bus1.b = 8'h04; bus1.cin = 1'b0; bus1.start = 1'b1;
      tick();
      bus1.start = 1'b0;
      repeat (3) tick();
      check("busy_at_run3", 32'(bus1.busy), 32'h1);
      bus1.a = 8'hAA; bus1.b = 8'h55; bus1.start = 1'b1;
      tick();
      bus1.start = 1'b0;
      dn  = 0;
      cap = '0;
      for (int i = 0; i < 14; i++) begin
         tick();
         if (bus1.done) begin
            dn++;
            cap = bus1.sum;
         end
      end
      check("ignore_start_done_count", 32'(dn), 32'd1);
      check("ignore_start_sum", 32'(cap), 32'h07);
      check("ignore_start_idle", 32'(bus1.busy), 32'h0);

      // Asynchronous reset in the middle of a run.
      bus1.a = 8'h11; bus1.b = 8'h22; bus1.start = 1'b1;
      tick();
      bus1.start = 1'b0;
      repeat (4) tick();
      #2 rst_n = 1'b0;
      #1;
      check("arst_sum",  32'(bus1.sum), 32'h0);
      check("arst_busy", 32'(bus1.busy), 32'h0);
      check("arst_done", 32'(bus1.done), 32'h0);
      check("arst_cout", 32'(bus1.cout), 32'h0);
      #2 rst_n = 1'b1;
      dn = 0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (bus1.done) dn++;
      end
      check("arst_no_done", 32'(dn), 32'd0);
      op1(8'h10, 8'h20, 1'b0, lat, bn);
      check("post_rst_sum", 32'(bus1.sum), 32'h30);
      check("post_rst_latency", 32'(lat), 32'd9);
      tick();

      // DIGIT=4: start held high gives back-to-back operations every 3 cycles.
      bus4.a = 8'h0F; bus4.b = 8'h01; bus4.cin = 1'b0; bus4.start = 1'b1;
      tick();
      check("b2b_busy_e0", 32'(bus4.busy), 32'h1);
      bus4.a = 8'h01; bus4.b = 8'h01;
      tick();
      check("b2b_done_e1", 32'(bus4.done), 32'h0);
      tick();
      check("b2b_done_e2", 32'(bus4.done), 32'h1);
      check("b2b_sum1",    32'(bus4.sum), 32'h10);
      check("b2b_busy_e2", 32'(bus4.busy), 32'h0);
      tick();
      check("b2b_busy_e3", 32'(bus4.busy), 32'h1);
      check("b2b_done_e3", 32'(bus4.done), 32'h0);
      check("b2b_sum_hold", 32'(bus4.sum), 32'h10);
      tick();
      tick();
      check("b2b_done_e5", 32'(bus4.done), 32'h1);
      check("b2b_sum2",    32'(bus4.sum), 32'h02);
      bus4.start = 1'b0;
      tick();
      check("b2b_done_e6", 32'(bus4.done), 32'h0);
      check("b2b_busy_e6", 32'(bus4.busy), 32'h0);

      // Carry-in with a carry crossing the digit boundary.
      bus4.a = 8'h3C; bus4.b = 8'h0A; bus4.cin = 1'b1; bus4.start = 1'b1;
      tick();
      bus4.start = 1'b0;
      tick();
      tick();
      check("cin_done", 32'(bus4.done), 32'h1);
      check("cin_sum",  32'(bus4.sum), 32'h47);
      check("cin_cout", 32'(bus4.cout), 32'h0);
      bus4.cin = 1'b0;
      tick();

`ifdef ADD_SUB_EN
      bus4.a = 8'h05; bus4.b = 8'h07; bus4.op = 1'b1; bus4.start = 1'b1;
      tick();
      bus4.start = 1'b0;
      bus4.op    = 1'b0;
      tick();
      tick();
      check("sub_done", 32'(bus4.done), 32'h1);
      check("sub_sum",  32'(bus4.sum), 32'hFE);
      check("sub_cout", 32'(bus4.cout), 32'h0);
      check("sub_ovf",  32'(bus4.overflow), 32'h0);
      tick();
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
